// File: rtl/display_tx.sv
// Buffered serial output port: captures bus words on dsp_in_en into a FIFO and
// transmits each word as two 8N1 frames, low byte first.
module display_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [15:0]                   in,
  input  logic                          dsp_in_en,
  output logic                          tx,
  output logic                          busy,
  output logic                          empty,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST_CLK = CW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   DEPTH_W  = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic [15:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_count, w_count_nxt;
  logic          r_empty, r_full, r_overflow;
  logic          w_push, w_pop;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_clk_cnt, w_clk_cnt_nxt;
  logic [2:0]    r_bit_idx, w_bit_idx_nxt;
  logic          r_byte_sel, w_byte_sel_nxt;
  logic [15:0]   r_word;
  logic [7:0]    w_byte;
  logic          r_tx, w_tx_nxt;

  // A push into an empty FIFO is not seen by the same-edge pop (r_empty is pre-edge).
  assign w_push = dsp_in_en & ~r_full;
  assign w_pop  = (r_state == S_IDLE) & ~r_empty;

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop)      w_count_nxt = r_count + (AW + 1)'(1);
    else if (!w_push && w_pop) w_count_nxt = r_count - (AW + 1)'(1);
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= in;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_empty    <= 1'b1;
      r_full     <= 1'b0;
      r_overflow <= 1'b0;
      r_word     <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
        r_word <= r_mem[r_rptr];
      end
      if (dsp_in_en && r_full) r_overflow <= 1'b1;
      r_count <= w_count_nxt;
      r_empty <= (w_count_nxt == '0);
      r_full  <= (w_count_nxt == DEPTH_W);
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_clk_cnt_nxt  = r_clk_cnt;
    w_bit_idx_nxt  = r_bit_idx;
    w_byte_sel_nxt = r_byte_sel;
    w_tx_nxt       = 1'b1;
    case (r_state)
      S_IDLE: begin
        if (!r_empty) begin
          w_state_nxt    = S_START;
          w_clk_cnt_nxt  = '0;
          w_byte_sel_nxt = 1'b0;
        end
      end
      S_START: begin
        if (r_clk_cnt == LAST_CLK) begin
          w_state_nxt   = S_DATA;
          w_clk_cnt_nxt = '0;
          w_bit_idx_nxt = '0;
        end else begin
          w_clk_cnt_nxt = r_clk_cnt + CW'(1);
        end
      end
      S_DATA: begin
        if (r_clk_cnt == LAST_CLK) begin
          w_clk_cnt_nxt = '0;
          if (r_bit_idx == 3'd7) w_state_nxt = S_STOP;
          else                   w_bit_idx_nxt = r_bit_idx + 3'd1;
        end else begin
          w_clk_cnt_nxt = r_clk_cnt + CW'(1);
        end
      end
      S_STOP: begin
        if (r_clk_cnt == LAST_CLK) begin
          w_clk_cnt_nxt = '0;
          if (!r_byte_sel) begin
            w_byte_sel_nxt = 1'b1;
            w_state_nxt    = S_START;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_clk_cnt_nxt = r_clk_cnt + CW'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // tx is registered from the next-state view so the line changes on the same edge as the state.
    w_byte = w_byte_sel_nxt ? r_word[15:8] : r_word[7:0];
    case (w_state_nxt)
      S_START: w_tx_nxt = 1'b0;
      S_DATA:  w_tx_nxt = w_byte[w_bit_idx_nxt];
      default: w_tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_clk_cnt  <= '0;
      r_bit_idx  <= '0;
      r_byte_sel <= 1'b0;
      r_tx       <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_clk_cnt  <= w_clk_cnt_nxt;
      r_bit_idx  <= w_bit_idx_nxt;
      r_byte_sel <= w_byte_sel_nxt;
      r_tx       <= w_tx_nxt;
    end
  end

  assign tx       = r_tx;
  assign busy     = (r_state != S_IDLE);
  assign empty    = r_empty;
  assign full     = r_full;
  assign count    = r_count;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_display_tx.sv
// Bench for display_tx: directed pushes feed an expected-byte queue; a serial
// receiver process decodes tx frames and checks them against that queue.
module tb_display_tx;
  localparam int CPB   = 4;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] din = '0;
  logic        en  = 1'b0;
  logic        tx, busy, empty, full, overflow;
  logic [3:0]  count;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  display_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in(din), .dsp_in_en(en), .tx(tx), .busy(busy),
    .empty(empty), .full(full), .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic e, input logic [15:0] w);
    @(negedge clk);
    en  = e;
    din = w;
  endtask

  task automatic expect_word(input logic [15:0] w);
    exp_q.push_back(w[7:0]);
    exp_q.push_back(w[15:8]);
  endtask

  task automatic wait_idle(input int limit);
    logic done;
    done = 1'b0;
    for (int k = 0; k < limit; k++) begin
      @(negedge clk);
      if (empty && !busy) begin
        done = 1'b1;
        break;
      end
    end
    chk("drain_done", {31'd0, done}, 32'd1);
  endtask

  // Serial receiver / scoreboard monitor
  int         m_state = 0;
  int         m_cnt   = 0;
  logic [7:0] m_byte;
  always @(negedge clk) begin
    if (!rst) begin
      m_state = 0;
    end else if (m_state == 0) begin
      if (tx == 1'b0) begin
        m_state = 1;
        m_cnt   = 0;
      end
    end else begin
      m_cnt++;
      if (m_cnt == CPB / 2) chk("start_bit", {31'd0, tx}, 32'd0);
      for (int b = 1; b <= 8; b++)
        if (m_cnt == b * CPB + CPB / 2) m_byte[b-1] = tx;
      if (m_cnt == 9 * CPB + CPB / 2) begin
        chk("stop_bit", {31'd0, tx}, 32'd1);
        if (exp_q.size() == 0) begin
          chk("unexpected_frame", {24'd0, m_byte}, 32'hFFFF_FFFF);
        end else begin
          chk("frame_byte", {24'd0, m_byte}, {24'd0, exp_q.pop_front()});
        end
        m_state = 0;
      end
    end
  end

  initial begin
    int nb;
    int gaps;
    logic [15:0] w;

    // 1: reset held with strobe active
    en  = 1'b1;
    din = 16'hFFFF;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("rst_tx", {31'd0, tx}, 32'd1);
      chk("rst_status", {27'd0, busy, empty, full, overflow, 1'b0}, {27'd0, 5'b01000});
      chk("rst_count", {28'd0, count}, 32'd0);
    end
    en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_rst_empty", {31'd0, empty}, 32'd1);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);

    // 2: single word timing
    drive(1'b1, 16'hA55A);
    expect_word(16'hA55A);
    drive(1'b0, 16'h0000);
    chk("cap_tx_high", {31'd0, tx}, 32'd1);
    chk("cap_count", {28'd0, count}, 32'd1);
    chk("cap_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk("start_tx_low", {31'd0, tx}, 32'd0);
    chk("start_empty", {31'd0, empty}, 32'd1);
    nb = 0;
    for (int k = 0; k < 200; k++) begin
      if (!busy) break;
      nb++;
      @(negedge clk);
    end
    chk("busy_cycles", nb, 32'd80);
    chk("single_done_tx", {31'd0, tx}, 32'd1);
    repeat (3) @(negedge clk);

    // 3: overflow
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 3) begin
        chk("ovf_first_pop_count", {28'd0, count}, 32'd1);
        chk("ovf_first_pop_busy", {31'd0, busy}, 32'd1);
      end
      if (i == 10) begin
        chk("ovf_full_after9", {31'd0, full}, 32'd1);
        chk("ovf_count_after9", {28'd0, count}, 32'd8);
        chk("ovf_not_yet", {31'd0, overflow}, 32'd0);
      end
      en  = 1'b1;
      din = 16'(i);
      if (i <= 9) expect_word(16'(i));
    end
    @(negedge clk);
    en = 1'b0;
    chk("ovf_flag", {31'd0, overflow}, 32'd1);
    chk("ovf_count_held", {28'd0, count}, 32'd8);
    gaps = 0;
    for (int k = 0; k < 2000; k++) begin
      if (empty && !busy) break;
      if (!busy) gaps++;
      @(negedge clk);
    end
    chk("ovf_idle_gaps", gaps, 32'd8);
    chk("ovf_drained", {31'd0, empty && !busy}, 32'd1);
    chk("ovf_sticky", {31'd0, overflow}, 32'd1);
    repeat (3) @(negedge clk);

    // 4: concurrent push and pop at the IDLE cycle
    drive(1'b1, 16'h1357); expect_word(16'h1357);
    drive(1'b1, 16'h2468); expect_word(16'h2468);
    drive(1'b1, 16'hBEEF); expect_word(16'hBEEF);
    drive(1'b1, 16'hCAFE); expect_word(16'hCAFE);
    drive(1'b0, 16'h0000);
    for (int k = 0; k < 200; k++) begin
      if (!busy) break;
      @(negedge clk);
    end
    chk("cc_pre_count", {28'd0, count}, 32'd3);
    chk("cc_pre_idle", {31'd0, busy}, 32'd0);
    en  = 1'b1;
    din = 16'h7E81;
    expect_word(16'h7E81);
    @(negedge clk);
    en = 1'b0;
    chk("cc_post_count", {28'd0, count}, 32'd3);
    chk("cc_post_busy", {31'd0, busy}, 32'd1);
    wait_idle(1000);
    repeat (3) @(negedge clk);

    // 5: reset during DATA bit 3 of the first byte, two words queued
    drive(1'b1, 16'hFFFF);
    drive(1'b1, 16'hFFFF);
    drive(1'b1, 16'hFFFF);
    drive(1'b0, 16'h0000);
    repeat (15) @(negedge clk);
    chk("mid_count", {28'd0, count}, 32'd2);
    #1 rst = 1'b0;
    #1;
    chk("mid_rst_tx", {31'd0, tx}, 32'd1);
    chk("mid_rst_count", {28'd0, count}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (100) @(negedge clk);
    chk("mid_quiet_empty", {31'd0, empty}, 32'd1);
    chk("mid_quiet_ovf", {31'd0, overflow}, 32'd0);
    drive(1'b1, 16'h1234);
    expect_word(16'h1234);
    drive(1'b0, 16'h0000);
    wait_idle(300);
    repeat (3) @(negedge clk);

    // 6: pointer wrap at a rate below the drain rate
    for (int i = 0; i < 20; i++) begin
      w = 16'hC3A5 ^ (16'(i) * 16'h0111);
      drive(1'b1, w);
      expect_word(w);
      drive(1'b0, 16'h0000);
      repeat (98) @(negedge clk);
    end
    wait_idle(300);
    repeat (3) @(negedge clk);
    chk("wrap_no_ovf", {31'd0, overflow}, 32'd0);
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
